// File: rtl/branch_pkg.sv
// Shared types and constants for the branch resolver: condition codes,
// 2-bit predictor counter states and the counter update helper.
package branch_pkg;

  typedef enum logic [2:0] {
    COND_NONE = 3'd0,
    COND_JUMP = 3'd1,
    COND_BEZ  = 3'd2,
    COND_BNE  = 3'd3,
    COND_BEQ  = 3'd4,
    COND_BLT  = 3'd5,
    COND_BGE  = 3'd6,
    COND_BLTU = 3'd7
  } cond_t;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  localparam int DEFAULT_BHT_ENTRIES = 16;

  // Saturating step of a 2-bit predictor counter toward the actual outcome.
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken && (ctr != CTR_ST)) begin
      nxt = ctr + 2'd1;
    end else if (!taken && (ctr != CTR_SNT)) begin
      nxt = ctr - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Purely combinational branch condition evaluation: maps a condition code
// and two operands to the actual taken/not-taken outcome.
module branch_cond_eval
  import branch_pkg::*;
#(
  parameter int WORD_LEN = 32
) (
  input  logic [2:0]          cond,
  input  logic [WORD_LEN-1:0] reg1,
  input  logic [WORD_LEN-1:0] reg2,
  output logic                taken
);

  always_comb begin
    taken = 1'b0;
    case (cond_t'(cond))
      COND_NONE: taken = 1'b0;
      COND_JUMP: taken = 1'b1;
      COND_BEZ:  taken = (reg1 == '0);
      COND_BNE:  taken = (reg1 != reg2);
      COND_BEQ:  taken = (reg1 == reg2);
      COND_BLT:  taken = ($signed(reg1) <  $signed(reg2));
      COND_BGE:  taken = ($signed(reg1) >= $signed(reg2));
      COND_BLTU: taken = (reg1 < reg2);
      default:   taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolver.sv
// Branch resolver: resolves EX-stage branches, trains a direct-mapped table
// of 2-bit counters for fetch prediction and flags mispredictions.
module branch_resolver
  import branch_pkg::*;
#(
  parameter int WORD_LEN    = 32,
  parameter int BHT_ENTRIES = DEFAULT_BHT_ENTRIES,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_LEN-1:0]  if_pc,
  output logic                 pred_taken,
  input  logic                 ex_valid,
  input  logic                 ex_stall,
  input  logic [2:0]           ex_cond,
  input  logic [WORD_LEN-1:0]  ex_pc,
  input  logic [WORD_LEN-1:0]  ex_target,
  input  logic                 ex_pred_taken,
  input  logic [WORD_LEN-1:0]  reg1,
  input  logic [WORD_LEN-1:0]  reg2,
  output logic                 br_taken,
  output logic                 flush,
  output logic [WORD_LEN-1:0]  redirect_pc,
  output logic [CNT_WIDTH-1:0] mispredict_cnt
);

  localparam int IDX = $clog2(BHT_ENTRIES);

  logic [1:0]           bht_q [BHT_ENTRIES];
  logic [1:0]           bht_d [BHT_ENTRIES];
  logic                 br_taken_q, br_taken_d;
  logic                 flush_q, flush_d;
  logic [WORD_LEN-1:0]  redirect_pc_q, redirect_pc_d;
  logic [CNT_WIDTH-1:0] mispredict_cnt_q, mispredict_cnt_d;

  logic [IDX-1:0] lookup_idx;
  logic [IDX-1:0] update_idx;
  logic           accept;
  logic           ex_taken;
  logic           mispredict;
  logic           unused_pc_bits;

  branch_cond_eval #(
    .WORD_LEN(WORD_LEN)
  ) u_cond_eval (
    .cond  (ex_cond),
    .reg1  (reg1),
    .reg2  (reg2),
    .taken (ex_taken)
  );

  // Word-aligned index, no tag: aliasing PCs share a counter.
  assign lookup_idx     = if_pc[IDX+1:2];
  assign update_idx     = ex_pc[IDX+1:2];
  assign unused_pc_bits = ^{if_pc[WORD_LEN-1:IDX+2], if_pc[1:0]};

  assign pred_taken = bht_q[lookup_idx][1];

  assign accept     = ex_valid && !ex_stall && (ex_cond != COND_NONE);
  assign mispredict = ex_taken ^ ex_pred_taken;

  always_comb begin
    bht_d            = bht_q;
    br_taken_d       = br_taken_q;
    flush_d          = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (accept) begin
      br_taken_d    = ex_taken;
      flush_d       = mispredict;
      redirect_pc_d = ex_taken ? ex_target : (ex_pc + WORD_LEN'(4));
      if (mispredict && !(&mispredict_cnt_q)) begin
        mispredict_cnt_d = mispredict_cnt_q + CNT_WIDTH'(1);
      end
      // Unconditional jumps carry no history worth learning.
      if (ex_cond != COND_JUMP) begin
        bht_d[update_idx] = ctr_next(bht_q[update_idx], ex_taken);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= CTR_WNT;
      end
      br_taken_q       <= 1'b0;
      flush_q          <= 1'b0;
      redirect_pc_q    <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      bht_q            <= bht_d;
      br_taken_q       <= br_taken_d;
      flush_q          <= flush_d;
      redirect_pc_q    <= redirect_pc_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign br_taken       = br_taken_q;
  assign flush          = flush_q;
  assign redirect_pc    = redirect_pc_q;
  assign mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver built with a 4-bit misprediction
// counter so saturation is reachable in a few cycles.
module tb_branch_resolver;
  import branch_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic        ex_valid;
  logic        ex_stall;
  logic [2:0]  ex_cond;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] reg1;
  logic [31:0] reg2;
  logic        br_taken;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [3:0]  mispredict_cnt;

  int assertCount;
  int failCount;
  int expCnt;

  branch_resolver #(
    .WORD_LEN    (32),
    .BHT_ENTRIES (16),
    .CNT_WIDTH   (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .if_pc          (if_pc),
    .pred_taken     (pred_taken),
    .ex_valid       (ex_valid),
    .ex_stall       (ex_stall),
    .ex_cond        (ex_cond),
    .ex_pc          (ex_pc),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .reg1           (reg1),
    .reg2           (reg2),
    .br_taken       (br_taken),
    .flush          (flush),
    .redirect_pc    (redirect_pc),
    .mispredict_cnt (mispredict_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      $error("[TB] %s observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic checkResolve(input string tag, input logic expBr, input logic expFlush,
                              input logic [31:0] expRedirect, input logic [3:0] expMis);
    checkOutput({tag, "/br_taken"}, {31'd0, br_taken}, {31'd0, expBr});
    checkOutput({tag, "/flush"}, {31'd0, flush}, {31'd0, expFlush});
    checkOutput({tag, "/redirect_pc"}, redirect_pc, expRedirect);
    checkOutput({tag, "/mispredict_cnt"}, {28'd0, mispredict_cnt}, {28'd0, expMis});
  endtask

  task automatic driveInputs(input logic v, input logic s, input logic [2:0] c,
                             input logic [31:0] pc, input logic [31:0] tgt,
                             input logic p, input logic [31:0] a, input logic [31:0] b);
    ex_valid      = v;
    ex_stall      = s;
    ex_cond       = c;
    ex_pc         = pc;
    ex_target     = tgt;
    ex_pred_taken = p;
    reg1          = a;
    reg2          = b;
  endtask

  task automatic clockCycle();
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
    ex_stall = 1'b0;
  endtask

  task automatic applyStimulus(input logic v, input logic s, input logic [2:0] c,
                               input logic [31:0] pc, input logic [31:0] tgt,
                               input logic p, input logic [31:0] a, input logic [31:0] b);
    driveInputs(v, s, c, pc, tgt, p, a, b);
    clockCycle();
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    rst         = 1'b1;
    if_pc       = 32'h40;
    driveInputs(1'b0, 1'b0, COND_NONE, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);

    // Reset state
    #12;
    checkResolve("reset", 1'b0, 1'b0, 32'h0, 4'd0);
    checkOutput("reset/pred_taken", {31'd0, pred_taken}, 32'd0);
    rst = 1'b0;
    clockCycle();

    // Two taken BEQ at 0x40: counter 01 -> 10 -> 11, first one mispredicts
    applyStimulus(1'b1, 1'b0, COND_BEQ, 32'h40, 32'h80, 1'b0, 32'd5, 32'd5);
    checkResolve("beq1", 1'b1, 1'b1, 32'h80, 4'd1);
    checkOutput("beq1/pred_taken", {31'd0, pred_taken}, 32'd1);
    applyStimulus(1'b1, 1'b0, COND_BEQ, 32'h40, 32'h80, 1'b1, 32'd5, 32'd5);
    checkResolve("beq2", 1'b1, 1'b0, 32'h80, 4'd1);
    checkOutput("beq2/pred_taken", {31'd0, pred_taken}, 32'd1);
    clockCycle();
    checkOutput("bubble/flush", {31'd0, flush}, 32'd0);

    // Signed vs unsigned compare of -1 and 1
    applyStimulus(1'b1, 1'b0, COND_BLT, 32'h204, 32'h300, 1'b1, 32'hFFFF_FFFF, 32'd1);
    checkOutput("blt/br_taken", {31'd0, br_taken}, 32'd1);
    checkOutput("blt/flush", {31'd0, flush}, 32'd0);
    applyStimulus(1'b1, 1'b0, COND_BLTU, 32'h204, 32'h300, 1'b0, 32'hFFFF_FFFF, 32'd1);
    checkOutput("bltu/br_taken", {31'd0, br_taken}, 32'd0);
    applyStimulus(1'b1, 1'b0, COND_BGE, 32'h204, 32'h300, 1'b0, 32'hFFFF_FFFF, 32'd1);
    checkOutput("bge/br_taken", {31'd0, br_taken}, 32'd0);
    checkOutput("bge/mispredict_cnt", {28'd0, mispredict_cnt}, 32'd1);

    // Back-to-back not-taken mispredicts, second one wraps pc+4
    if_pc = 32'h100;
    applyStimulus(1'b1, 1'b0, COND_BNE, 32'h100, 32'h900, 1'b1, 32'd7, 32'd7);
    checkResolve("bne1", 1'b0, 1'b1, 32'h104, 4'd2);
    checkOutput("bne1/pred_taken", {31'd0, pred_taken}, 32'd1);
    applyStimulus(1'b1, 1'b0, COND_BNE, 32'hFFFF_FFFC, 32'h900, 1'b1, 32'd7, 32'd7);
    checkResolve("bne_wrap", 1'b0, 1'b1, 32'h0, 4'd3);
    clockCycle();
    applyStimulus(1'b1, 1'b0, COND_BNE, 32'h100, 32'h900, 1'b1, 32'd7, 32'd7);
    checkResolve("bne2", 1'b0, 1'b1, 32'h104, 4'd4);
    checkOutput("bne2/pred_taken", {31'd0, pred_taken}, 32'd0);

    // Stall, NONE and JUMP
    if_pc = 32'h40;
    applyStimulus(1'b1, 1'b1, COND_BEZ, 32'h40, 32'h500, 1'b0, 32'd0, 32'd3);
    checkResolve("stall", 1'b0, 1'b0, 32'h104, 4'd4);
    checkOutput("stall/pred_taken", {31'd0, pred_taken}, 32'd0);
    applyStimulus(1'b1, 1'b0, COND_NONE, 32'h40, 32'h500, 1'b1, 32'd0, 32'd3);
    checkResolve("none", 1'b0, 1'b0, 32'h104, 4'd4);
    applyStimulus(1'b1, 1'b0, COND_JUMP, 32'h40, 32'h600, 1'b0, 32'd0, 32'd0);
    checkResolve("jump", 1'b1, 1'b1, 32'h600, 4'd5);
    checkOutput("jump/pred_taken", {31'd0, pred_taken}, 32'd0);

    // Same-cycle lookup and update at one index returns the old value
    driveInputs(1'b1, 1'b0, COND_BEQ, 32'h40, 32'h80, 1'b0, 32'd1, 32'd1);
    #2;
    checkOutput("collide/pred_before", {31'd0, pred_taken}, 32'd0);
    clockCycle();
    checkResolve("collide", 1'b1, 1'b1, 32'h80, 4'd6);
    checkOutput("collide/pred_after", {31'd0, pred_taken}, 32'd1);

    // Drive the 4-bit count into saturation and one beyond
    expCnt = 6;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0, COND_JUMP, 32'h40, 32'h700 + 32'(i * 4), 1'b0, 32'd0, 32'd0);
      expCnt = (expCnt < 15) ? expCnt + 1 : 15;
      checkOutput("sat/mispredict_cnt", {28'd0, mispredict_cnt}, 32'(expCnt));
      checkOutput("sat/flush", {31'd0, flush}, 32'd1);
    end
    checkOutput("sat/final", {28'd0, mispredict_cnt}, 32'hF);

    // Async reset between edges during a mispredicting resolve
    driveInputs(1'b1, 1'b0, COND_JUMP, 32'h40, 32'hA00, 1'b0, 32'd0, 32'd0);
    #3;
    rst = 1'b1;
    #1;
    checkResolve("async_rst", 1'b0, 1'b0, 32'h0, 4'd0);
    checkOutput("async_rst/pred_taken", {31'd0, pred_taken}, 32'd0);
    ex_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    clockCycle();
    checkResolve("post_rst", 1'b0, 1'b0, 32'h0, 4'd0);
    if_pc = 32'hFFFF_FFFC;
    #1;
    checkOutput("post_rst/pred_idx15", {31'd0, pred_taken}, 32'd0);
    if_pc = 32'h40;
    applyStimulus(1'b1, 1'b0, COND_BEQ, 32'h40, 32'h80, 1'b0, 32'd9, 32'd9);
    checkResolve("post_rst_beq", 1'b1, 1'b1, 32'h80, 4'd1);
    checkOutput("post_rst_beq/pred_taken", {31'd0, pred_taken}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
